// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, memory-wait freezes, timeout error.
// Latency: stall outputs are combinational (zero cycle); state, error flag and counter are registered.
// Backpressure: a pending memory access freezes the back end and holds PC/IF-ID; an error freezes forever.
module hazard_stall_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             ID_UseRs1_i,
  input  logic             ID_UseRs2_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             MEM_Req_i,
  input  logic             MEM_Ack_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             NoOp_o,
  output logic             Freeze_o,
  output logic             Mem_Err_o,
  output logic [CNT_W-1:0] Stall_Cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  // 17 bits so the largest legal TIMEOUT compares without truncation.
  localparam logic [16:0] TIMEOUT_L = 17'(TIMEOUT);

  state_t           state;
  logic [15:0]      wait_cnt;
  logic [16:0]      wait_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             ms;

  // Hazard detection; an error state keeps the memory stall asserted permanently.
  always_comb begin
    lu = EX_MemRead_i && (EX_Rd_i != 5'd0) &&
         ((ID_UseRs1_i && (ID_Rs1_i == EX_Rd_i)) ||
          (ID_UseRs2_i && (ID_Rs2_i == EX_Rd_i)));
    ms = (state == ERROR) || (MEM_Req_i && !MEM_Ack_i);
    wait_nxt = {1'b0, wait_cnt} + 17'd1;
  end

  // Stall outputs: freeze beats bubble; while in reset the pipeline runs freely.
  always_comb begin
    PC_Write_o    = 1'b1;
    IF_ID_Write_o = 1'b1;
    NoOp_o        = 1'b0;
    Freeze_o      = 1'b0;
    if (rst_i) begin
      if (ms) begin
        PC_Write_o    = 1'b0;
        IF_ID_Write_o = 1'b0;
        Freeze_o      = 1'b1;
      end else if (lu) begin
        PC_Write_o    = 1'b0;
        IF_ID_Write_o = 1'b0;
        NoOp_o        = 1'b1;
      end
    end
  end

  // Memory wait FSM with timeout; ERROR is left only through reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (MEM_Req_i && !MEM_Ack_i) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (MEM_Ack_i || !MEM_Req_i) begin
            state <= RUN;
          end else begin
            wait_cnt <= wait_nxt[15:0];
            if (wait_nxt >= TIMEOUT_L) begin
              state <= ERROR;
            end
          end
        end
        ERROR:   state <= ERROR;
        default: state <= RUN;
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held (one per cycle, however many causes).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
    end else if (!PC_Write_o && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign Mem_Err_o   = (state == ERROR);
  assign Stall_Cnt_o = stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl (TIMEOUT=4, CNT_W=4).
// Each step drives one cycle of inputs and pushes the hand-derived expected outputs;
// the negedge sampler pops them and compares against the DUT.
module tb_hazard_stall_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [4:0] ID_Rs1_i = '0;
  logic [4:0] ID_Rs2_i = '0;
  logic       ID_UseRs1_i = 1'b0;
  logic       ID_UseRs2_i = 1'b0;
  logic       EX_MemRead_i = 1'b0;
  logic [4:0] EX_Rd_i = '0;
  logic       MEM_Req_i = 1'b0;
  logic       MEM_Ack_i = 1'b0;
  logic       PC_Write_o;
  logic       IF_ID_Write_o;
  logic       NoOp_o;
  logic       Freeze_o;
  logic       Mem_Err_o;
  logic [3:0] Stall_Cnt_o;

  hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ID_Rs1_i     (ID_Rs1_i),
    .ID_Rs2_i     (ID_Rs2_i),
    .ID_UseRs1_i  (ID_UseRs1_i),
    .ID_UseRs2_i  (ID_UseRs2_i),
    .EX_MemRead_i (EX_MemRead_i),
    .EX_Rd_i      (EX_Rd_i),
    .MEM_Req_i    (MEM_Req_i),
    .MEM_Ack_i    (MEM_Ack_i),
    .PC_Write_o   (PC_Write_o),
    .IF_ID_Write_o(IF_ID_Write_o),
    .NoOp_o       (NoOp_o),
    .Freeze_o     (Freeze_o),
    .Mem_Err_o    (Mem_Err_o),
    .Stall_Cnt_o  (Stall_Cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       pc;
    logic       noop;
    logic       frz;
    logic       err;
    logic [3:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs after the edge, push expectation, compare at the falling edge.
  task automatic step(input string tag, input logic r,
                      input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u1, input logic u2, input logic mrd, input logic [4:0] rd,
                      input logic req, input logic ack,
                      input logic e_pc, input logic e_noop, input logic e_frz,
                      input logic e_err, input int e_cnt);
    exp_t e;
    exp_t g;
    @(posedge clk_i);
    #1;
    rst_i = r; ID_Rs1_i = rs1; ID_Rs2_i = rs2; ID_UseRs1_i = u1; ID_UseRs2_i = u2;
    EX_MemRead_i = mrd; EX_Rd_i = rd; MEM_Req_i = req; MEM_Ack_i = ack;
    e.pc = e_pc; e.noop = e_noop; e.frz = e_frz; e.err = e_err; e.cnt = 4'(e_cnt);
    exp_q.push_back(e);
    @(negedge clk_i);
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check_eq({tag, ".pc"},    32'(PC_Write_o),    32'(g.pc));
      check_eq({tag, ".ifid"},  32'(IF_ID_Write_o), 32'(g.pc));
      check_eq({tag, ".noop"},  32'(NoOp_o),        32'(g.noop));
      check_eq({tag, ".frz"},   32'(Freeze_o),      32'(g.frz));
      check_eq({tag, ".err"},   32'(Mem_Err_o),     32'(g.err));
      check_eq({tag, ".cnt"},   32'(Stall_Cnt_o),   32'(g.cnt));
    end
  endtask

  // Reset cycle with hazards present on the inputs: outputs must still show free-running.
  task automatic reset_cycle(input string tag);
    step(tag, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1, 0, 0, 0, 0);
  endtask

  task automatic idle(input string tag, input logic e_err, input int e_cnt);
    step(tag, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1, 0, 0, e_err, e_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    reset_cycle("rst0");
    idle("rst0_rel", 0, 0);

    // Single load-use on rs2: exactly one bubble
    step("lu_rs2", 1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 0, 1, 0, 0, 0);
    idle("lu_after", 0, 1);
    // x0 destination and unused operand: no stall
    step("lu_x0",  1'b1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    step("lu_nou", 1'b1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    // Non-load producer: no stall
    step("lu_nold", 1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    // Load-use on rs1
    step("lu_rs1", 1'b1, 5'd3, 5'd9, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 0, 1, 0, 0, 1);
    idle("lu_rs1_after", 0, 2);

    // Memory wait, ack on 4th cycle: 3 frozen cycles
    reset_cycle("rst1");
    step("mw1",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 0);
    step("mw2",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 1);
    step("mw3",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 2);
    step("mwack",1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1, 0, 0, 0, 3);
    idle("mw_done", 0, 3);

    // Simultaneous LU and MS: no bubble while frozen, bubble in ack cycle
    reset_cycle("rst2");
    step("sim1",  1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 0, 0, 1, 0, 0);
    step("sim2",  1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 0, 0, 1, 0, 1);
    step("simack",1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 0, 1, 0, 0, 2);
    idle("sim_done", 0, 3);

    // Request dropped during wait: back to RUN, no error
    reset_cycle("rst3");
    step("drop1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 0);
    step("drop2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1, 0, 0, 0, 1);
    idle("drop3", 0, 1);
    // Reset in the middle of a wait aborts it
    step("abrt1", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 1);
    step("abrt2", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 2);
    reset_cycle("abrt_rst");
    idle("abrt_rel", 0, 0);

    // Timeout: one RUN request cycle, 4 wait cycles, then ERROR
    step("to_run", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      step($sformatf("to_w%0d", i), 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0,
           0, 0, 1, 0, i);
    end
    step("to_err",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 0, 0, 1, 1, 5);
    step("to_ack",  1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 0, 0, 1, 1, 6);
    step("to_noreq",1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 0, 0, 1, 1, 7);
    reset_cycle("to_rst");
    idle("to_rel", 0, 0);

    // Saturation: 20 stalled cycles, counter holds at 15
    for (int i = 0; i < 20; i++) begin
      step($sformatf("sat%0d", i), 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0,
           0, 1, 0, 0, (i > 15) ? 15 : i);
    end
    idle("sat_hold", 0, 15);
    idle("sat_hold2", 0, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
